// File: rtl/div_pkg.sv
// Shared state encoding and sizing helper for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Minimum 1 bit so an N=2 divider still has a counter to wrap.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// W-bit ripple adder/subtractor: k=1 inverts b and injects a carry-in of 1.
module div_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         k,
  output logic [W-1:0] sum
);

  logic [W-1:0] bx;
  logic [W-1:0] c;

  assign bx   = b ^ {W{k}};
  assign c[0] = k;

  // Carry out of the MSB is intentionally not generated.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i] = a[i] ^ bx[i] ^ c[i];
    if (i < W - 1) begin : g_carry
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/seq_divider_nr.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (sign fix-up folded into the FIX cycle).
module seq_divider_nr
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = clog2(N);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  dz_pend;
  logic                  accept;
  logic [N-1:0]          a_reg;
  logic [N-1:0]          d_reg;
  logic signed [N:0]     p_reg;
  logic [N:0]            p_sh;
  logic [N-1:0]          a_sh;
  logic [N:0]            add_a;
  logic [N:0]            add_sum;
  logic                  add_k;
  logic [N-1:0]          rem_raw;
  logic [N-1:0]          q_out;
  logic [N-1:0]          r_out;
  logic [N-1:0]          dz_rem;

`ifdef DIV_SIGNED_EN
  logic                  q_neg;
  logic                  r_neg;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [N-1:0] neg_if(input logic [N-1:0] v, input logic s);
    return s ? (~v + 1'b1) : v;
  endfunction
`endif

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dz_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= '0;
        dz_pend <= (divisor == '0);
      end else if (state == RUN) begin
        cnt <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == CW'(N - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single shared adder: RUN step uses the shifted remainder, FIX adds D back.
  assign p_sh = {p_reg[N-1:0], a_reg[N-1]};
  assign a_sh = {a_reg[N-2:0], 1'b0};

  always_comb begin
    add_a = p_sh;
    add_k = ~p_reg[N];
    if (state == FIX) begin
      add_a = p_reg;
      add_k = 1'b0;
    end
  end

  div_addsub #(.W(N + 1)) u_addsub (
    .a   (add_a),
    .b   ({1'b0, d_reg}),
    .k   (add_k),
    .sum (add_sum)
  );

  assign rem_raw = p_reg[N] ? add_sum[N-1:0] : p_reg[N-1:0];

`ifdef DIV_SIGNED_EN
  assign q_out  = neg_if(a_reg, q_neg);
  assign r_out  = neg_if(rem_raw, r_neg);
  assign dz_rem = neg_if(a_reg, r_neg);
`else
  assign q_out  = a_reg;
  assign r_out  = rem_raw;
  assign dz_rem = a_reg;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      p_reg <= '0;
`ifdef DIV_SIGNED_EN
      a_reg <= mag(dividend);
      d_reg <= mag(divisor);
      q_neg <= dividend[N-1] ^ divisor[N-1];
      r_neg <= dividend[N-1];
`else
      a_reg <= dividend;
      d_reg <= divisor;
`endif
    end else if (state == RUN) begin
      p_reg <= add_sum;
      a_reg <= {a_sh[N-1:1], ~add_sum[N]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_by_zero <= 1'b0;
      end else if (state == FIX) begin
        quotient  <= q_out;
        remainder <= r_out;
        done      <= 1'b1;
      end else if (state == DONE && dz_pend) begin
        quotient    <= '1;
        remainder   <= dz_rem;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_nr.sv
// Directed self-checking bench for seq_divider_nr (N=4); signed vectors when DIV_SIGNED_EN is defined.
module tb_seq_divider_nr;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_chk;
  int n_fail;

  seq_divider_nr #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered just after an edge; returns 1ns after the edge where the FSM is back in IDLE.
  task automatic run_div(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
    int lat;
    lat = edz ? 1 : N + 1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k < lat) begin
        chk({nm, " done_early"}, 32'(done), 32'd0);
        chk({nm, " busy_run"}, 32'(busy), 32'd1);
      end
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " quotient"}, 32'(quotient), 32'(eq));
    chk({nm, " remainder"}, 32'(remainder), 32'(er));
    chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    chk({nm, " busy_at_done"}, 32'(busy), edz ? 32'd0 : 32'd1);
    @(posedge clk);
    #1;
    chk({nm, " done_pulse_end"}, 32'(done), 32'd0);
    chk({nm, " busy_idle"}, 32'(busy), 32'd0);
    chk({nm, " quotient_held"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef DIV_SIGNED_EN
    run_div("s -7/2", 4'h9, 4'h2, 4'hD, 4'hF, 1'b0);
    run_div("s -8/-1", 4'h8, 4'hF, 4'h8, 4'h0, 1'b0);
    run_div("s 7/-2", 4'h7, 4'hE, 4'hD, 4'h1, 1'b0);
    run_div("s -5/0", 4'hB, 4'h0, 4'hF, 4'hB, 1'b1);
    run_div("s 6/3", 4'h6, 4'h3, 4'h2, 4'h0, 1'b0);
`else
    run_div("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    run_div("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    run_div("3/9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
    run_div("0/5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    run_div("7/0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    run_div("14/4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

    // A start pulse during RUN must not disturb the in-flight 13/3.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ignore done", 32'(done), 32'd1);
    chk("ignore quotient", 32'(quotient), 32'd4);
    chk("ignore remainder", 32'(remainder), 32'd1);
    @(posedge clk);
    #1;
    chk("ignore idle", 32'(busy), 32'd0);

    // Run 10/3 to leave nonzero results, then reset mid-RUN of 13/3.
    run_div("10/3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst quotient", 32'(quotient), 32'd0);
    chk("midrst remainder", 32'(remainder), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_div("9/2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
